alu_sequencer: RTL and testbench

Registered front-end and back-end for the combinational ALU. It accepts operation requests over a valid/ready handshake, drives the ALU operand and opcode inputs from held registers, and captures the ALU result and flags. It returns the outcome over a second valid/ready handshake and maintains the architectural NZCV status register, including condition-code evaluation for the branch unit. It sits between decode/issue and writeback in the CPU datapath.

---
 rtl/alu_sequencer_pkg.sv | 21 ++
 rtl/alu_sequencer_if.sv | 25 ++
 rtl/alu_sequencer_cond_eval.sv | 23 ++
 rtl/alu_sequencer.sv | 91 +++++++++
 tb/tb_alu_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared ALU opcodes, NZCV bit indices, condition-code and sequencer state enums
package alu_sequencer_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MAX  = 4'b1010;
  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;
  typedef enum logic [3:0] {CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC, CC_AL} cond_t;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/response valid-ready bundle; master = issuer/consumer, slave = sequencer
interface alu_sequencer_if #(parameter int WIDTH = 32, parameter int TAG_W = 4);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       req_op;
  logic             req_use_carry;
  logic             req_set_flags;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_illegal;
  logic [TAG_W-1:0] rsp_tag;
  modport master (
    output req_valid, req_a, req_b, req_op, req_use_carry, req_set_flags, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_illegal, rsp_tag
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, req_use_carry, req_set_flags, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_illegal, rsp_tag
  );
endinterface

// File: rtl/alu_sequencer_cond_eval.sv
// alu_sequencer_cond_eval: cond (4) x flags {N,Z,C,V} (4) -> cond_true; EQ..AL, 9-15 false
module alu_sequencer_cond_eval
  import alu_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);
  always_comb begin
    case (cond)
      CC_EQ:   cond_true = flags[F_Z];
      CC_NE:   cond_true = !flags[F_Z];
      CC_CS:   cond_true = flags[F_C];
      CC_CC:   cond_true = !flags[F_C];
      CC_MI:   cond_true = flags[F_N];
      CC_PL:   cond_true = !flags[F_N];
      CC_VS:   cond_true = flags[F_V];
      CC_VC:   cond_true = !flags[F_V];
      CC_AL:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: clk/rst, bus (req/rsp handshakes), alu_* drive/capture, flags_q NZCV, cond -> cond_true
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_sequencer_if.slave   bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             alu_n,
  output logic [3:0]       flags_q,
  input  logic [3:0]       cond,
  output logic             cond_true
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]       op_q, op_d, rflags_q, rflags_d, flags_d;
  logic             uc_q, uc_d, sf_q, sf_d, ill_q, ill_d;
  logic [TAG_W-1:0] tag_q, tag_d, rtag_q, rtag_d;
  logic             exec, hold_done, acc;
  assign exec = state_q == S_EXEC;
  assign hold_done = state_q == S_HOLD && bus.rsp_ready;
  assign bus.req_ready = state_q == S_IDLE || hold_done;
  assign acc = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = state_q == S_HOLD;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags = rflags_q;
  assign bus.rsp_illegal = ill_q;
  assign bus.rsp_tag = rtag_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  assign alu_cin = exec && uc_q && flags_q[F_C];
  always_comb begin
    state_d = exec ? S_HOLD : acc ? S_EXEC : hold_done ? S_IDLE : state_q;
    a_d = acc ? bus.req_a : a_q;
    b_d = acc ? bus.req_b : b_q;
    op_d = acc ? bus.req_op : op_q;
    uc_d = acc ? bus.req_use_carry : uc_q;
    sf_d = acc ? bus.req_set_flags : sf_q;
    tag_d = acc ? bus.req_tag : tag_q;
    res_d = exec ? alu_result : res_q;
    rflags_d = exec ? {alu_n, alu_z, alu_c, alu_v} : rflags_q;
    ill_d = exec ? op_q > OP_MAX : ill_q;
    rtag_d = exec ? tag_q : rtag_q;
    flags_d = exec && sf_q ? {alu_n, alu_z, alu_c, alu_v} : flags_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      uc_q <= 1'b0;
      sf_q <= 1'b0;
      tag_q <= '0;
      res_q <= '0;
      rflags_q <= '0;
      ill_q <= 1'b0;
      rtag_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      uc_q <= uc_d;
      sf_q <= sf_d;
      tag_q <= tag_d;
      res_q <= res_d;
      rflags_q <= rflags_d;
      ill_q <= ill_d;
      rtag_q <= rtag_d;
      flags_q <= flags_d;
    end
  end
  alu_sequencer_cond_eval u_cond (
    .cond      (cond),
    .flags     (flags_q),
    .cond_true (cond_true)
  );
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random + directed check of alu_sequencer against a transaction-level model
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op, flags_q, cond;
  logic        alu_cin, alu_z, alu_c, alu_v, alu_n, cond_true;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [3:0]  mflags = 4'b0;
  bit          pending = 1'b0;
  always #5 clk = ~clk;
  alu_sequencer_if #(.WIDTH(32), .TAG_W(4)) bus ();
  alu_sequencer #(.WIDTH(32), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .alu_n      (alu_n),
    .flags_q    (flags_q),
    .cond       (cond),
    .cond_true  (cond_true)
  );
  function automatic logic [35:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic cin);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b} + {32'b0, cin};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $signed(a) >>> b[4:0];
      OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: r = {31'b0, a < b};
      default: r = '0;
    endcase
    return {r[31], r == 32'b0, c, v, r};
  endfunction
  always_comb {alu_n, alu_z, alu_c, alu_v, alu_result} = alu_f(alu_a, alu_b, alu_op, alu_cin);
  function automatic logic cond_ref(int c, logic [3:0] f);
    logic [15:0] tbl;
    tbl = {7'b0, 1'b1, !f[0], f[0], !f[3], f[3], !f[1], f[1], !f[2], f[2]};
    return tbl[c];
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_cond(int c);
    cond = 4'(c);
    #1;
    check($sformatf("cond%0d", c), cond_true, cond_ref(c, mflags));
  endtask
  task automatic do_req(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic uc, logic sf, logic [3:0] tag, int hold);
    logic [35:0] e;
    if (pending) bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_op = op;
    bus.req_use_carry = uc;
    bus.req_set_flags = sf;
    bus.req_tag = tag;
    #1;
    check("req_ready_accept", bus.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    pending = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_a = $urandom;
    bus.req_b = $urandom;
    bus.req_op = 4'($urandom);
    #1;
    check("exec_rsp_valid", bus.rsp_valid, 1'b0);
    check("exec_req_ready", bus.req_ready, 1'b0);
    check("exec_alu_a", alu_a, a);
    check("exec_alu_b", alu_b, b);
    check("exec_alu_op", alu_op, op);
    check("exec_alu_cin", alu_cin, uc & mflags[F_C]);
    e = alu_f(a, b, op, uc & mflags[F_C]);
    if (sf) mflags = e[35:32];
    @(posedge clk);
    @(negedge clk);
    check("rsp_valid", bus.rsp_valid, 1'b1);
    check("rsp_result", bus.rsp_result, e[31:0]);
    check("rsp_flags", bus.rsp_flags, e[35:32]);
    check("rsp_illegal", bus.rsp_illegal, op > 4'd10);
    check("rsp_tag", bus.rsp_tag, tag);
    check("flags_q", flags_q, mflags);
    check("hold_alu_cin", alu_cin, 1'b0);
    check_cond($urandom_range(15));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_rsp_valid", bus.rsp_valid, 1'b1);
      check("bp_req_ready", bus.req_ready, 1'b0);
      check("bp_rsp_result", bus.rsp_result, e[31:0]);
      check("bp_rsp_flags", bus.rsp_flags, e[35:32]);
      check("bp_rsp_tag", bus.rsp_tag, tag);
    end
    pending = 1'b1;
  endtask
  task automatic drain();
    if (pending) begin
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      pending = 1'b0;
      check("drain_rsp_valid", bus.rsp_valid, 1'b0);
      check("drain_req_ready", bus.req_ready, 1'b1);
    end
  endtask
  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_rsp_valid", bus.rsp_valid, 1'b0);
    end
  endtask
  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.req_use_carry = 1'b0;
    bus.req_set_flags = 1'b0;
    bus.req_tag = '0;
    bus.rsp_ready = 1'b0;
    cond = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_flags_q", flags_q, 4'b0);
    check("rst_alu_op", alu_op, 4'b0);
    check("rst_alu_a", alu_a, 32'b0);
    check("rst_alu_cin", alu_cin, 1'b0);
    cond = 4'd8;
    #1;
    check("rst_cond_al", cond_true, 1'b1);
    cond = 4'd0;
    #1;
    check("rst_cond_eq", cond_true, 1'b0);
    do_req(32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b0, 1'b1, 4'd3, 0);
    check("add_result", bus.rsp_result, 32'h8000_0000);
    check("add_tag", bus.rsp_tag, 4'd3);
    check("add_flags_q", flags_q, 4'b1001);
    check_cond(4);
    check_cond(6);
    do_req(32'd5, 32'd5, OP_SUB, 1'b0, 1'b0, 4'd5, 5);
    check("sub_result", bus.rsp_result, 32'b0);
    check("sub_z", bus.rsp_flags[F_Z], 1'b1);
    check("sub_flags_q", flags_q, 4'b1001);
    check_cond(0);
    do_req(32'hFFFF_FFFF, 32'h1, OP_ADD, 1'b0, 1'b1, 4'd9, 0);
    do_req(32'h10, 32'h20, OP_ADD, 1'b1, 1'b0, 4'd10, 0);
    check("carry_chain", bus.rsp_result, 32'h31);
    do_req(32'h1234, 32'h5678, 4'b1111, 1'b0, 1'b1, 4'd7, 1);
    check("ill_result", bus.rsp_result, 32'b0);
    check("ill_flag", bus.rsp_illegal, 1'b1);
    check("ill_flags_q", flags_q, 4'b0100);
    drain();
    for (int c = 0; c < 16; c++) check_cond(c);
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(3) == 0) rb = ra;
      if ($urandom_range(3) == 0) ra = 32'($urandom_range(3));
      rop = ($urandom_range(7) == 0) ? 4'($urandom_range(15, 11)) : 4'($urandom_range(10));
      if ($urandom_range(2) != 0) begin
        drain();
        idle($urandom_range(2));
      end
      do_req(ra, rb, rop, 1'($urandom), 1'($urandom), 4'($urandom), $urandom_range(2));
    end
    drain();
    for (int c = 0; c < 16; c++) check_cond(c);
    bus.req_valid = 1'b1;
    bus.req_a = 32'd1;
    bus.req_b = 32'd1;
    bus.req_op = OP_ADD;
    bus.req_use_carry = 1'b0;
    bus.req_set_flags = 1'b1;
    bus.req_tag = 4'd2;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mflags = 4'b0;
    check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("mid_rst_req_ready", bus.req_ready, 1'b1);
    check("mid_rst_flags_q", flags_q, 4'b0);
    idle(3);
    check("mid_rst_flags_after", flags_q, 4'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
